beat_note_fifo: RTL
===================

BEAT_NOTE_FIFO -- requirements
Module: beat_note_fifo

Interface
- REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, 2..16.
- REQ-002 SHALL have parameter BEAT_DIV, default 16: clk cycles per beat; minimum 2.
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port data_en, input, 1 bit: note-code write strobe from the beatmap data generator.
- REQ-006 SHALL have port data, input, 8 bits: note code, sampled when data_en=1.
- REQ-007 SHALL have port play_en, input, 1 bit: beat timer run enable.
- REQ-008 SHALL have port note_valid, output, 1 bit: one-cycle pulse for a playable note.
- REQ-009 SHALL have port note_code, output, 8 bits: last popped code.
- REQ-010 SHALL have port note_lane, output, 2 bits: lane of the last popped code.
- REQ-011 SHALL have port fifo_count, output, 5 bits: current occupancy, range 0..DEPTH.
- REQ-012 SHALL have port overflow, output, 1 bit: sticky flag; a write was dropped.
- REQ-013 SHALL have port underrun, output, 1 bit: sticky flag; a beat occurred with the FIFO empty.

Function
- REQ-014 SHALL push data into the FIFO on any cycle with data_en=1 and fifo_count<DEPTH, or with fifo_count=DEPTH when a pop occurs in the same cycle.
- REQ-015 SHALL, when data_en=1, fifo_count=DEPTH and no same-cycle pop occur, drop the write, leave FIFO contents unchanged and set overflow.
- REQ-016 SHALL run the beat counter 0..BEAT_DIV-1 while play_en=1, wrapping from BEAT_DIV-1 to 0.
- REQ-017 SHALL clear the beat counter to 0 on any cycle with play_en=0.
- REQ-018 SHALL assert an internal beat_tick for exactly one cycle, the cycle in which the counter equals BEAT_DIV-1 and play_en=1.
- REQ-019 SHALL, on beat_tick with fifo_count>0, pop the head entry.
- REQ-020 SHALL, on the cycle after a pop, register note_code as the head value and note_lane as head[3:2].
- REQ-021 SHALL, on the cycle after a pop, set note_valid=1 when the head is nonzero; head=0 is a rest (note_valid=0, code and lane still updated).
- REQ-022 SHALL, on beat_tick with fifo_count=0 and no same-cycle push, pop nothing, keep note_code and note_lane, drive note_valid=0 and set underrun.
- REQ-023 SHALL, on beat_tick with fifo_count=0 and a same-cycle push, also set underrun; the pushed word is poppable no earlier than the next beat_tick.
- REQ-024 SHALL make note_valid a single-cycle pulse, deasserted on every cycle not directly following a nonzero-head pop.
- REQ-025 SHALL make fifo_count exact under simultaneous push and pop: unchanged when both occur, +1 for a push only, -1 for a pop only.
- REQ-026 SHALL wrap the read and write pointers modulo DEPTH.
- REQ-027 SHALL preserve strict FIFO order.
- REQ-028 SHALL keep overflow and underrun set until reset, with no other clear path.

Reset
- REQ-029 SHALL, on resetn=0 and independent of clk, force: note_valid=0, note_code=0, note_lane=0, fifo_count=0, overflow=0, underrun=0, beat counter=0, pointers=0.
- REQ-030 SHALL, on reset assertion mid-operation, discard all buffered entries.
- REQ-031 SHALL accept no push and produce no beat_tick while resetn=0.
- REQ-032 SHALL treat the first clk edge after resetn rises as counter value 0 when play_en=1.

Verification
- REQ-033 Ordering (BEAT_DIV=4): push 200,204,208,212,216, then play_en=1 -> note_valid pulses every 4 cycles; codes C8/CC/D0/D4/D8; lanes 2,3,0,1,2.
- REQ-034 Overflow (DEPTH=8): push 9 words with play_en=0 -> fifo_count=8, overflow=1, ninth word absent from the pops.
- REQ-035 Rest/underrun: push 0x00 then 0xC8, play 3 beats -> beat 1: note_valid=0, note_code=0x00; beat 2: valid, lane 2; beat 3: underrun=1, note_code stays 0xC8.
- REQ-036 Full with simultaneous push and pop: FIFO full, data_en=1 on a beat_tick cycle -> fifo_count stays 8, overflow=0, new word is popped 8 beats later.
- REQ-037 Reset mid-play: resetn=0 with 5 entries buffered -> all outputs 0 immediately without a clk edge; after release, a beat with no push sets underrun=1.
- REQ-038 play_en gating: drop play_en at counter=2, raise it again -> next beat_tick exactly BEAT_DIV-1 cycles after the rising edge.

Source files
------------

// File: rtl/beat_note_fifo.sv
// Note-code FIFO drained one entry per beat; popped code/lane/valid appear the cycle after the beat.
// Writes into a full FIFO are dropped (sticky overflow) unless a pop frees a slot in the same cycle.
module beat_note_fifo #(
  parameter int DEPTH    = 8,
  parameter int BEAT_DIV = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       data_en,
  input  logic [7:0] data,
  input  logic       play_en,
  output logic       note_valid,
  output logic [7:0] note_code,
  output logic [1:0] note_lane,
  output logic [4:0] fifo_count,
  output logic       overflow,
  output logic       underrun
);

  localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW        = $clog2(BEAT_DIV);
  localparam logic [4:0]      FULL_CNT  = 5'(DEPTH);
  localparam logic [CW-1:0]   BEAT_LAST = CW'(BEAT_DIV - 1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic [CW-1:0] r_beat_cnt;
  logic          r_note_valid;
  logic [7:0]    r_note_code;
  logic [1:0]    r_note_lane;
  logic          r_overflow;
  logic          r_underrun;

  logic          w_beat_tick;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [7:0]    w_head;

  assign w_beat_tick = play_en && (r_beat_cnt == BEAT_LAST);
  assign w_empty     = (r_count == 5'd0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = w_beat_tick && !w_empty;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign w_push      = data_en && (!w_full || w_pop);
  assign w_drop      = data_en && w_full && !w_pop;
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_cnt <= '0;
    end else if (!play_en || w_beat_tick) begin
      r_beat_cnt <= '0;
    end else begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_note_valid <= 1'b0;
      r_note_code  <= 8'd0;
      r_note_lane  <= 2'd0;
      r_overflow   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_note_valid <= w_pop && (w_head != 8'd0);
      if (w_pop) begin
        r_note_code <= w_head;
        r_note_lane <= w_head[3:2];
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_beat_tick && w_empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign note_valid = r_note_valid;
  assign note_code  = r_note_code;
  assign note_lane  = r_note_lane;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign underrun   = r_underrun;

endmodule
